// File: rtl/ram_arb_pkg.sv
// Shared constants, requester index type and grant-selection helpers for ram_port_arbiter.
// RAM_ARB_FIXED_PRIO_EN selects fixed_pick instead of rr_pick in the arbiter.
package ram_arb_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned N_REQ  = 4;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef logic [1:0] req_idx_t;

  // Search starts just after the previous winner and wraps, so the last winner goes last.
  function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input req_idx_t          last_gnt);
    logic [N_REQ-1:0] g;
    logic             found;
    req_idx_t         idx;
    g     = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = req_idx_t'(32'(last_gnt) + k);
      if (!found && req[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic logic [N_REQ-1:0] fixed_pick(input logic [N_REQ-1:0] req);
    logic [N_REQ-1:0] g;
    logic             found;
    g     = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!found && req[k]) begin
        g[k]  = 1'b1;
        found = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic req_idx_t onehot_idx(input logic [N_REQ-1:0] oh);
    req_idx_t idx;
    idx = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (oh[k]) idx = req_idx_t'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ram_sp_16x8.sv
// Single-port synchronous RAM; a write also returns the written word on rdata.
// Asynchronous active-low reset clears every entry and the read register.
module ram_sp_16x8 #(
  parameter int unsigned DATA_W = ram_arb_pkg::DATA_W,
  parameter int unsigned ADDR_W = ram_arb_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata     <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one 16x8 single-port RAM between four requesters, one access per cycle.
// Round-robin by default; define RAM_ARB_FIXED_PRIO_EN for fixed priority (0 highest).
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned DATA_W = ram_arb_pkg::DATA_W,
  parameter int unsigned ADDR_W = ram_arb_pkg::ADDR_W,
  parameter int unsigned N_REQ  = ram_arb_pkg::N_REQ
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        we,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  input  logic [N_REQ*DATA_W-1:0] wdata,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]       rdata,
  output logic                    busy
);

  req_idx_t          last_gnt;
  req_idx_t          win;
  logic              acc_en;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  always_comb begin
    gnt = '0;
`ifdef RAM_ARB_FIXED_PRIO_EN
    gnt = fixed_pick(req);
`else
    gnt = rr_pick(req, last_gnt);
`endif
  end

  // Winner's request fields steer the single RAM port.
  always_comb begin
    win       = onehot_idx(gnt);
    acc_en    = |req;
    sel_we    = we[win];
    sel_addr  = addr[win*ADDR_W +: ADDR_W];
    sel_wdata = wdata[win*DATA_W +: DATA_W];
  end

  ram_sp_16x8 #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (acc_en),
    .we    (sel_we),
    .addr  (sel_addr),
    .wdata (sel_wdata),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid   <= '0;
      last_gnt <= req_idx_t'(N_REQ - 1);
      busy     <= 1'b0;
    end else begin
      rvalid <= gnt;
      busy   <= acc_en;
      if (acc_en) last_gnt <= win;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed-vector bench for ram_port_arbiter with hand-computed expectations.
// Contention tests follow the build: round-robin, or fixed priority under RAM_ARB_FIXED_PRIO_EN.
module tb_ram_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  we;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [3:0]  rvalid;
  logic [7:0]  rdata;
  logic        busy;

  int unsigned errors;
  int unsigned checks;

  ram_port_arbiter #(
    .DATA_W (8),
    .ADDR_W (4),
    .N_REQ  (4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .gnt    (gnt),
    .rvalid (rvalid),
    .rdata  (rdata),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic w, input logic [3:0] a, input logic [7:0] d);
    req[i]          = 1'b1;
    we[i]           = w;
    addr[i*4 +: 4]  = a;
    wdata[i*8 +: 8] = d;
  endtask

  initial begin
    logic [3:0] exp_g [5];
    logic [7:0] exp_d [5];
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    req    = '0;
    we     = '0;
    addr   = '0;
    wdata  = '0;

    #12;
    check("rst_rdata", 32'(rdata), 32'h00);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_gnt", 32'(gnt), 32'h0);
    rst_n = 1'b1;
    tick();

    // Single read by requester 2 at addr 5
    set_req(2, 1'b0, 4'd5, 8'h00);
    #1 check("rd2_gnt", 32'(gnt), 32'b0100);
    tick();
    check("rd2_rvalid", 32'(rvalid), 32'b0100);
    check("rd2_rdata", 32'(rdata), 32'h00);
    check("rd2_busy", 32'(busy), 32'h1);
    req = '0;
    #1 check("idle_gnt", 32'(gnt), 32'h0);

    // Requester 0 writes A5 to addr 3, requester 1 reads it back
    set_req(0, 1'b1, 4'd3, 8'hA5);
    #1 check("wr0_gnt", 32'(gnt), 32'b0001);
    tick();
    check("wr0_rvalid", 32'(rvalid), 32'b0001);
    check("wr0_rdata", 32'(rdata), 32'hA5);
    req = '0;
    set_req(1, 1'b0, 4'd3, 8'h00);
    #1 check("rd1_gnt", 32'(gnt), 32'b0010);
    tick();
    check("rd1_rvalid", 32'(rvalid), 32'b0010);
    check("rd1_rdata", 32'(rdata), 32'hA5);

`ifndef RAM_ARB_FIXED_PRIO_EN
    // last_gnt = 1, requesters 1 and 3 contend
    req = '0;
    set_req(1, 1'b0, 4'd3, 8'h00);
    set_req(3, 1'b0, 4'd0, 8'h00);
    #1 check("ct_gnt0", 32'(gnt), 32'b1000);
    tick();
    check("ct_rvalid0", 32'(rvalid), 32'b1000);
    check("ct_rdata0", 32'(rdata), 32'h00);
    req[3] = 1'b0;
    #1 check("ct_gnt1", 32'(gnt), 32'b0010);
    tick();
    check("ct_rvalid1", 32'(rvalid), 32'b0010);
    check("ct_rdata1", 32'(rdata), 32'hA5);
`endif

    // Idle cycle: rvalid drops, rdata holds, busy clears
    req = '0;
    tick();
    check("idle_rvalid", 32'(rvalid), 32'h0);
    check("idle_rdata", 32'(rdata), 32'hA5);
    check("idle_busy", 32'(busy), 32'h0);

    // Top address through requester 3, read back by requester 2
    set_req(3, 1'b1, 4'd15, 8'h5A);
    #1 check("wr3_gnt", 32'(gnt), 32'b1000);
    tick();
    check("wr3_rdata", 32'(rdata), 32'h5A);
    req = '0;
    set_req(2, 1'b0, 4'd15, 8'h00);
    #1 check("rd15_gnt", 32'(gnt), 32'b0100);
    tick();
    check("rd15_rvalid", 32'(rvalid), 32'b0100);
    check("rd15_rdata", 32'(rdata), 32'h5A);
    req = '0;
    set_req(0, 1'b0, 4'd3, 8'h00);
    #1 check("rd3_gnt", 32'(gnt), 32'b0001);
    tick();
    check("rd3_rdata", 32'(rdata), 32'hA5);

    // Reset the cycle after a write of 3C to addr 7
    req = '0;
    set_req(0, 1'b1, 4'd7, 8'h3C);
    tick();
    check("wr7_rvalid", 32'(rvalid), 32'b0001);
    check("wr7_rdata", 32'(rdata), 32'h3C);
    req   = '0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rvalid", 32'(rvalid), 32'h0);
    check("mid_rst_rdata", 32'(rdata), 32'h00);
    rst_n = 1'b1;
    set_req(0, 1'b0, 4'd7, 8'h00);
    #1 check("rd7_gnt", 32'(gnt), 32'b0001);
    tick();
    check("rd7_rvalid", 32'(rvalid), 32'b0001);
    check("rd7_rdata", 32'(rdata), 32'h00);
    set_req(0, 1'b0, 4'd3, 8'h00);
    tick();
    check("rd3_clr_rdata", 32'(rdata), 32'h00);

    // All four held high from reset, each writing its own address
    req   = '0;
    rst_n = 1'b0;
    #1;
    set_req(0, 1'b1, 4'd0, 8'h11);
    set_req(1, 1'b1, 4'd1, 8'h22);
    set_req(2, 1'b1, 4'd2, 8'h33);
    set_req(3, 1'b1, 4'd3, 8'h44);
    rst_n = 1'b1;
`ifndef RAM_ARB_FIXED_PRIO_EN
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    for (int k = 0; k < 5; k++) begin
      #1 check($sformatf("rr_gnt%0d", k), 32'(gnt), 32'(exp_g[k]));
      tick();
      check($sformatf("rr_rvalid%0d", k), 32'(rvalid), 32'(exp_g[k]));
      check($sformatf("rr_rdata%0d", k), 32'(rdata), 32'(exp_d[k]));
    end
`else
    exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    exp_d = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h11};
    req[1] = 1'b0;
    req[2] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1 check($sformatf("fp_gnt%0d", k), 32'(gnt), 32'(exp_g[k]));
      tick();
      check($sformatf("fp_rvalid%0d", k), 32'(rvalid), 32'(exp_g[k]));
      check($sformatf("fp_rdata%0d", k), 32'(rdata), 32'(exp_d[k]));
    end
`endif

    req = '0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
